// File: rtl/pixel_downscaler_if.sv
// Pixel-stream input and frame-buffer write bus of the box-filter downscaler.
interface pixel_downscaler_if #(
    parameter int unsigned CH = 3,
    parameter int unsigned CW = 4,
    parameter int unsigned AW = 19
) ();
    logic [1:0]       scale_sel;
    logic             vsync;
    logic             pix_valid;
    logic [CH*CW-1:0] pix_data;
    logic [AW-1:0]    wr_addr;
    logic [CH*CW-1:0] wr_data;
    logic             we;
    logic             frame_done;

    modport master (
        output scale_sel, vsync, pix_valid, pix_data,
        input  wr_addr, wr_data, we, frame_done
    );

    modport slave (
        input  scale_sel, vsync, pix_valid, pix_data,
        output wr_addr, wr_data, we, frame_done
    );
endinterface

// File: rtl/pixel_downscaler.sv
// N x N box-filter downscaler (N = 1/2/4 per frame) writing averaged blocks row-major.
module pixel_downscaler #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned CH    = 3,
    parameter int unsigned CW    = 4,
    parameter int unsigned AW    = 19
) (
    input  logic               pclk,
    input  logic               rst,
    pixel_downscaler_if.slave  bus
);
    localparam int unsigned PW    = CH * CW;
    localparam int unsigned HW    = CW + 2;
    localparam int unsigned LW    = CW + 4;
    localparam int unsigned XW    = $clog2(IMG_W);
    localparam int unsigned YW    = $clog2(IMG_H + 1);
    localparam int unsigned DEPTH = IMG_W / 2;
    localparam int unsigned LAW   = $clog2(DEPTH);

    typedef enum logic {WAIT_SYNC, RUN} state_t;

    state_t            state_q, state_d;
    logic              vs1_q, vs1_d, vs2_q, vs2_d;
    logic [1:0]        lg_q, lg_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [CH*HW-1:0]  h_acc_q, h_acc_d;
    logic [AW-1:0]     addr_cnt_q, addr_cnt_d;
    logic              wrote_q, wrote_d;

    logic              s0_vld_q, s0_vld_d, s0_first_q, s0_first_d, s0_last_q, s0_last_d;
    logic [CH*HW-1:0]  s0_sum_q, s0_sum_d;
    logic [LAW-1:0]    s0_col_q, s0_col_d;
    logic [AW-1:0]     s0_addr_q, s0_addr_d;
    logic [1:0]        s0_lg_q, s0_lg_d;

    logic              s1_vld_q, s1_vld_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
    logic [CH*HW-1:0]  s1_sum_q, s1_sum_d;
    logic [LAW-1:0]    s1_col_q, s1_col_d;
    logic [AW-1:0]     s1_addr_q, s1_addr_d;
    logic [1:0]        s1_lg_q, s1_lg_d;

    logic              we_q, we_d, frame_done_q, frame_done_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [PW-1:0]     wr_data_q, wr_data_d;

    logic [CH*LW-1:0]  line_acc_mem [DEPTH];
    logic [CH*LW-1:0]  rd_q;

    logic              start_c, accept_c, col_done_c, emit_c, line_wr_c;
    logic [XW-1:0]     xmask_c;
    logic [YW-1:0]     ymask_c;
    logic [CH*HW-1:0]  h_sum_c;
    logic [CH*LW-1:0]  tot_c;

    assign bus.we         = we_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = frame_done_q;

    // Next-state: frame control, accept/count stage, read stage, add/output stage
    always_comb begin
        state_d     = state_q;
        vs1_d       = bus.vsync;
        vs2_d       = vs1_q;
        lg_d        = lg_q;
        x_d         = x_q;
        y_d         = y_q;
        h_acc_d     = h_acc_q;
        addr_cnt_d  = addr_cnt_q;
        s0_vld_d    = 1'b0;
        s0_first_d  = s0_first_q;
        s0_last_d   = s0_last_q;
        s0_sum_d    = s0_sum_q;
        s0_col_d    = s0_col_q;
        s0_addr_d   = s0_addr_q;
        s0_lg_d     = s0_lg_q;
        s1_vld_d    = s0_vld_q;
        s1_first_d  = s0_first_q;
        s1_last_d   = s0_last_q;
        s1_sum_d    = s0_sum_q;
        s1_col_d    = s0_col_q;
        s1_addr_d   = s0_addr_q;
        s1_lg_d     = s0_lg_q;
        we_d        = 1'b0;
        wr_data_d   = wr_data_q;
        wr_addr_d   = wr_addr_q;
        line_wr_c   = 1'b0;

        start_c    = vs1_q & ~vs2_q;
        xmask_c    = XW'((32'd1 << lg_q) - 32'd1);
        ymask_c    = YW'((32'd1 << lg_q) - 32'd1);
        accept_c   = bus.pix_valid & ~bus.vsync & (state_q == RUN) &
                     (y_q < YW'(IMG_H)) & ~start_c;
        col_done_c = (x_q & xmask_c) == xmask_c;

        for (int k = 0; k < CH; k++) begin
            h_sum_c[k*HW +: HW] = (((x_q & xmask_c) == '0) ? HW'(0) : h_acc_q[k*HW +: HW]) +
                                  HW'(bus.pix_data[k*CW +: CW]);
            tot_c[k*LW +: LW]   = s1_first_q ? LW'(s1_sum_q[k*HW +: HW]) :
                                  rd_q[k*LW +: LW] + LW'(s1_sum_q[k*HW +: HW]);
        end

        if (start_c) begin
            state_d    = RUN;
            x_d        = '0;
            y_d        = '0;
            h_acc_d    = '0;
            addr_cnt_d = '0;
            case (bus.scale_sel)
                2'd1:    lg_d = 2'd1;
                2'd2:    lg_d = 2'd2;
                default: lg_d = 2'd0;
            endcase
        end else if (accept_c) begin
            h_acc_d = h_sum_c;
            if (x_q == XW'(IMG_W - 1)) begin
                x_d = '0;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
            if (col_done_c) begin
                s0_vld_d   = 1'b1;
                s0_sum_d   = h_sum_c;
                s0_col_d   = LAW'(x_q >> lg_q);
                s0_first_d = (y_q & ymask_c) == '0;
                s0_last_d  = (y_q & ymask_c) == ymask_c;
                s0_addr_d  = addr_cnt_q;
                s0_lg_d    = lg_q;
                if ((y_q & ymask_c) == ymask_c) addr_cnt_d = addr_cnt_q + AW'(1);
            end
        end

        // Last line of a block emits the average; earlier lines bank the partial sum
        emit_c = s1_vld_q & s1_last_q;
        if (s1_vld_q & ~s1_last_q) line_wr_c = 1'b1;
        if (emit_c) begin
            we_d      = 1'b1;
            wr_addr_d = s1_addr_q;
            for (int k = 0; k < CH; k++)
                wr_data_d[k*CW +: CW] = CW'(tot_c[k*LW +: LW] >> {s1_lg_q, 1'b0});
        end else if (start_c) begin
            wr_addr_d = '0;
        end else if (we_q) begin
            wr_addr_d = wr_addr_q + AW'(1);
        end

        frame_done_d = start_c & wrote_q;
        wrote_d      = start_c ? emit_c : (wrote_q | emit_c);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_SYNC;
            vs1_q        <= 1'b0;
            vs2_q        <= 1'b0;
            lg_q         <= 2'd0;
            x_q          <= '0;
            y_q          <= '0;
            h_acc_q      <= '0;
            addr_cnt_q   <= '0;
            wrote_q      <= 1'b0;
            s0_vld_q     <= 1'b0;
            s0_first_q   <= 1'b0;
            s0_last_q    <= 1'b0;
            s0_sum_q     <= '0;
            s0_col_q     <= '0;
            s0_addr_q    <= '0;
            s0_lg_q      <= 2'd0;
            s1_vld_q     <= 1'b0;
            s1_first_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_sum_q     <= '0;
            s1_col_q     <= '0;
            s1_addr_q    <= '0;
            s1_lg_q      <= 2'd0;
            we_q         <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs1_q        <= vs1_d;
            vs2_q        <= vs2_d;
            lg_q         <= lg_d;
            x_q          <= x_d;
            y_q          <= y_d;
            h_acc_q      <= h_acc_d;
            addr_cnt_q   <= addr_cnt_d;
            wrote_q      <= wrote_d;
            s0_vld_q     <= s0_vld_d;
            s0_first_q   <= s0_first_d;
            s0_last_q    <= s0_last_d;
            s0_sum_q     <= s0_sum_d;
            s0_col_q     <= s0_col_d;
            s0_addr_q    <= s0_addr_d;
            s0_lg_q      <= s0_lg_d;
            s1_vld_q     <= s1_vld_d;
            s1_first_q   <= s1_first_d;
            s1_last_q    <= s1_last_d;
            s1_sum_q     <= s1_sum_d;
            s1_col_q     <= s1_col_d;
            s1_addr_q    <= s1_addr_d;
            s1_lg_q      <= s1_lg_d;
            we_q         <= we_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Per-column line accumulator: synchronous read in stage 1, write-back in stage 2
    always_ff @(posedge pclk) begin
        rd_q <= line_acc_mem[s0_col_q];
        if (line_wr_c) line_acc_mem[s1_col_q] <= tot_c;
    end
endmodule

// File: doc/pixel_downscaler.md
# pixel_downscaler

Parametrised pixel-stream box-filter downscaler between the camera capture stage and the frame buffer write port, in the `pclk` domain. It takes one full-resolution pixel per `pix_valid`, averages N×N blocks (N = 1, 2 or 4, selected per frame), and emits one frame-buffer write per block with a row-major address. It replaces fixed address truncation with true decimation and averaging, for any channel count and width.

## Interface
- `IMG_W`, 640, input pixels per line; must be a multiple of 4.
- `IMG_H`, 480, input lines per frame; must be a multiple of 4.
- `CH`, 3, colour channels per pixel.
- `CW`, 4, bits per channel.
- `AW`, 19, write-address width; must satisfy 2^AW ≥ IMG_W*IMG_H.
- `pclk`  in  1  pixel clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `scale_sel`  in  2  0 = 1×, 1 = 2×, 2 = 4×, 3 = reserved (treated as 1×). Sampled only at frame start.
- `vsync`  in  1  frame sync, active high. Its rising edge starts a frame.
- `pix_valid`  in  1  `pix_data` is valid this cycle.
- `pix_data`  in  CH*CW  pixel; channel k is in bits [k*CW +: CW].
- `wr_addr`  out  AW  frame-buffer write address.
- `wr_data`  out  CH*CW  averaged pixel, same packing as `pix_data`.
- `we`  out  1  write strobe, one cycle per output pixel.
- `frame_done`  out  1  one-cycle pulse at frame start when the previous frame produced at least one write.

## Operation
- **States:** `WAIT_SYNC` (after reset) and `RUN`.
  - Any `vsync` rising edge (registered `vsync` 0→1) enters `RUN` and starts a frame.
  - Frame start loads N from `scale_sel` and clears x, y, `wr_addr` and the horizontal accumulators.
  - Frame start pulses `frame_done` if at least one `we` occurred since the previous start.
- **Ignored pixels:** pixels are ignored while `vsync` = 1, in `WAIT_SYNC`, and once y = IMG_H (lines past the end of the frame).
- **Counters:** each accepted pixel increments x. When x = IMG_W-1, x wraps to 0 and y increments.
- **Horizontal sum:** per channel, h_acc sums N consecutive pixels. Width is CW+2 bits.
- **Column completion:** at x mod N = N-1, column c = x/N is complete with sum s.
  - N = 1: the output value is s directly.
  - y mod N = 0: line_acc[c] = s.
  - Otherwise: line_acc[c] += s.
  - line_acc has IMG_W/2 entries of CH*(CW+4) bits. It uses synchronous read and write and needs no reset.
- **Output:** at y mod N = N-1, the block outputs the block total >> (2·log2 N) per channel, truncated with no rounding. `we` = 1 and `wr_data` holds the result.
  - `wr_addr` is the block index, row-major. Valid range is 0 .. (IMG_W/N)*(IMG_H/N)-1.
  - `wr_addr` increments the cycle after each `we` and is never reused within a frame.
- **Scale changes:** a `scale_sel` change mid-frame has no effect until the next frame start.
- **Reset:** returns to `WAIT_SYNC` with `we` = 0, `frame_done` = 0, `wr_addr` = 0, `wr_data` = 0 and N = 1. Any in-flight pipeline writes are discarded.
- **Frame start during an incomplete block:** a new frame start mid-frame discards partial sums. Any writes already in the pipeline still complete with their original addresses.

## Timing
- **Latency:** 2 cycles for all N. `we` is asserted exactly 2 `pclk` edges after the edge that accepts the final contributing pixel.
- **Pipeline:** stage 1 reads line_acc; stage 2 adds, writes line_acc back and registers the outputs.
- **Read/write hazard:** consecutive column completions are at least 2 cycles apart for N ≥ 2, so there is no read/write collision. N = 1 bypasses line_acc.
- **Throughput:** one pixel per cycle; `pix_valid` may be high continuously. Output rate is at most 1 write per N² pixels.
- **Registered outputs:** `wr_addr`, `wr_data` and `we` change together and are held stable only in the `we` cycle. Outside `we` cycles `wr_data` is don't-care and `wr_addr` holds the next address.
- **frame_done:** asserted the cycle after the `vsync` rising edge is detected, i.e. 2 edges after `vsync` goes high.

## Test plan
Bench parameters: IMG_W = 8, IMG_H = 4, CH = 3, CW = 4.

1. **1× pass-through:** `scale_sel` = 0, vsync pulse, then 32 back-to-back pixels with `pix_data` = 12'h000..12'h01F. Required: 32 `we` pulses, `wr_addr` 0..31, `wr_data` equal to each input, each exactly 2 cycles after its input.
2. **2× uniform:** `scale_sel` = 1, all pixels 12'hF0A. Required: 8 writes, `wr_addr` 0..7, `wr_data` = 12'hF0A. Writes occur only during lines 1 and 3.
3. **4× averaging truncation:** `scale_sel` = 2. The red channel in the first 4×4 block is 0..15 (raster order, sum 120); all other channels are 0. Required: 2 writes; write 0 has red = 7 (120>>4), green = 0, blue = 0.
4. **Scale latched per frame:** `scale_sel` switches 0→1 after 10 pixels of a 1× frame. Required: the current frame still produces 32 writes. The next vsync edge pulses `frame_done` once, and the following frame produces 8 writes.
5. **Reset mid-frame:** assert `rst` after 13 pixels. Required: `we`, `wr_addr`, `wr_data` and `frame_done` are 0 immediately. No `we` occurs for further pixels until a vsync rising edge; the next frame then restarts at `wr_addr` 0.
6. **Ignored pixels:** drive 6 lines instead of 4, and drive `pix_valid` pixels while `vsync` = 1. Required: exactly 32 writes at 1×, none from lines 5–6 or from the vsync-high cycles. `frame_done` pulses at the next start; no pulse occurs after a frame with zero writes.
